// File: rtl/uart_rx_deserializer.sv
// UART receive engine: synchronizes rxd, deserializes frames and holds one result for a
// valid/ready consumer. Define UART_RX_MAJORITY_EN for 3-sample majority voting per bit.
module uart_rx_deserializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic [3:0]            data_bits,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  two_stop,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  break_err,
    output logic                  overrun_err
);
    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam int unsigned HALF = OVERSAMPLE / 2;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0] DW4 = 4'(DATA_WIDTH);
`ifdef UART_RX_MAJORITY_EN
    // Decision is made on the third of the three votes.
    localparam logic [OS_W-1:0] SAMPLE_PT = OS_W'(HALF);
`else
    localparam logic [OS_W-1:0] SAMPLE_PT = OS_W'(HALF - 1);
`endif

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBrkWait
    } state_e;

    state_e state_q, state_d;

    // Input synchronizer; resets to the idle level so reset release is not a start edge.
    logic [1:0] sync_q;
    logic       rxs_prev_q;
    logic       rxs;
    logic       fall;

    assign rxs  = sync_q[1];
    assign fall = rxs_prev_q & ~rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rxd};
            rxs_prev_q <= rxs;
        end
    end

    // Free-running divider; the load flag makes the count read as baud_div out of reset.
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_cur;
    logic                 div_load_q;
    logic                 tick;

    assign div_cur = div_load_q ? baud_div : div_cnt_q;
    assign tick    = (div_cur == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            div_load_q <= 1'b1;
        end else begin
            div_load_q <= 1'b0;
            div_cnt_q  <= tick ? baud_div : div_cur - DIV_WIDTH'(1);
        end
    end

    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic            in_frame;
    logic            sample_evt;
    logic            bit_val;

    assign in_frame   = (state_q == StStart) || (state_q == StData) ||
                        (state_q == StParity) || (state_q == StStop);
    assign sample_evt = tick && in_frame && (os_cnt_q == SAMPLE_PT);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_q <= 2'b11;
        end else if (tick) begin
            maj_q <= {maj_q[0], rxs};
        end
    end

    assign bit_val = (maj_q[1] & maj_q[0]) | (maj_q[1] & rxs) | (maj_q[0] & rxs);
`else
    assign bit_val = rxs;
`endif

    // Per-frame configuration and deserializer state.
    logic [3:0]            nbits_q, nbits_d;
    logic                  par_en_q, par_en_d;
    logic                  par_odd_q, par_odd_d;
    logic                  two_stop_q, two_stop_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop_low_q, stop_low_d;
    logic                  stop_idx_q, stop_idx_d;

    logic last_data;
    logic last_stop;
    logic is_break;
    logic complete;

    assign last_data = (bit_cnt_q == nbits_q - 4'd1);
    assign last_stop = ~two_stop_q | stop_idx_q;
    assign is_break  = (state_q == StStop) && !stop_idx_q && !bit_val && (shift_q == '0) &&
                       !(par_en_q && par_bit_q);

    // Holding register.
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  berr_q, berr_d;
    logic                  ovr_q, ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (fall) state_d = StStart;
            StStart:   if (sample_evt) state_d = bit_val ? StIdle : StData;
            StData:    if (sample_evt && last_data) state_d = par_en_q ? StParity : StStop;
            StParity:  if (sample_evt) state_d = StStop;
            StStop: begin
                if (sample_evt) begin
                    if (is_break) begin
                        state_d = StBrkWait;
                    end else if (last_stop) begin
                        state_d = StIdle;
                    end
                end
            end
            StBrkWait: if (rxs) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        os_cnt_d   = os_cnt_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        stop_low_d = stop_low_q;
        stop_idx_d = stop_idx_q;
        complete   = 1'b0;

        if (state_q == StIdle) begin
            if (fall) begin
                os_cnt_d   = '0;
                nbits_d    = (data_bits >= 4'd5 && data_bits <= DW4) ? data_bits : DW4;
                par_en_d   = parity_en;
                par_odd_d  = parity_odd;
                two_stop_d = two_stop;
                bit_cnt_d  = '0;
                shift_d    = '0;
                par_bit_d  = 1'b0;
                stop_low_d = 1'b0;
                stop_idx_d = 1'b0;
            end
        end else if (tick) begin
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
        end

        if (sample_evt) begin
            case (state_q)
                StData: begin
                    shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                StParity: par_bit_d = bit_val;
                StStop: begin
                    stop_low_d = stop_low_q | ~bit_val;
                    stop_idx_d = 1'b1;
                    complete   = is_break | last_stop;
                end
                default: ;
            endcase
        end

        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        berr_d  = berr_q;
        ovr_d   = 1'b0;
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (complete) begin
            if (!valid_q || rx_ready) begin
                // Data arrives at the top of the shifter; realign to bit 0.
                data_d  = shift_q >> (DW4 - nbits_q);
                perr_d  = par_en_q & (par_bit_q ^ (^shift_q) ^ par_odd_q);
                ferr_d  = stop_low_q | ~bit_val;
                berr_d  = is_break;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt_q   <= '0;
            nbits_q    <= DW4;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            stop_low_q <= 1'b0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            berr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            os_cnt_q   <= os_cnt_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            stop_low_q <= stop_low_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            berr_q     <= berr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_q;
    assign framing_err = ferr_q;
    assign break_err   = berr_q;
    assign overrun_err = ovr_q;

endmodule
